spike_rate_decoder: RTL and testbench

Decodes the spike train produced by the LIF neuron back into a number: it counts spike rising edges over a fixed power-of-two window and reports the spike rate, and optionally the inter-spike interval (ISI). It is the receiving end of the neuron's spike output. It sits alongside the neuron inside the TinyTapeout top, with `spike` fed from the neuron's spike bit and `rate`/`isi` driven onto spare output pins.

---
 rtl/lif_pkg.sv | 18 +
 rtl/spike_isi_meter.sv | 57 +++++
 rtl/spike_rate_decoder.sv | 101 ++++++++++
 tb/tb_spike_rate_decoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and constants for the spike-train decoder.
package lif_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dec_state_t;

    localparam int         RATE_W  = 8;
    localparam int         ISI_W   = 8;
    localparam logic [7:0] SAT_MAX = 8'd255;

    // Add a single bit to an 8-bit count without wrapping past 255.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic b);
        return (a == SAT_MAX) ? a : a + {7'd0, b};
    endfunction

endpackage

// File: rtl/spike_isi_meter.sv
// Inter-spike interval meter: measures cycles between consecutive spike edges.
// Instantiated by spike_rate_decoder only when SPIKE_ISI_EN is defined.
module spike_isi_meter
    import lif_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             evt,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid
);

    logic             armed_q, armed_d;
    logic [ISI_W-1:0] ivl_cnt_q, ivl_cnt_d;
    logic [ISI_W-1:0] isi_q, isi_d;
    logic             isi_valid_q, isi_valid_d;

    // Count restarts at 1 on every edge so the next edge sees exactly t2-t1.
    always_comb begin
        armed_d     = armed_q;
        ivl_cnt_d   = ivl_cnt_q;
        isi_d       = isi_q;
        isi_valid_d = 1'b0;
        if (!run) begin
            armed_d   = 1'b0;
            ivl_cnt_d = '0;
        end else if (evt) begin
            if (armed_q) begin
                isi_d       = ivl_cnt_q;
                isi_valid_d = 1'b1;
            end
            armed_d   = 1'b1;
            ivl_cnt_d = 8'd1;
        end else if (armed_q) begin
            ivl_cnt_d = sat_add(ivl_cnt_q, 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            ivl_cnt_q   <= '0;
            isi_q       <= '0;
            isi_valid_q <= 1'b0;
        end else begin
            armed_q     <= armed_d;
            ivl_cnt_q   <= ivl_cnt_d;
            isi_q       <= isi_d;
            isi_valid_q <= isi_valid_d;
        end
    end

    assign isi       = isi_q;
    assign isi_valid = isi_valid_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spike rising edges per 2^WIN_W-cycle window.
// Define SPIKE_ISI_EN to add the inter-spike interval outputs.
module spike_rate_decoder
    import lif_pkg::*;
#(
    parameter int WIN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              spike,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid,
`ifdef SPIKE_ISI_EN
    output logic [ISI_W-1:0]  isi,
    output logic              isi_valid,
`endif
    output logic              busy
);

    localparam logic [WIN_W-1:0] WIN_LAST = {WIN_W{1'b1}};

    dec_state_t        state_q, state_d;
    logic              spike_q;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [RATE_W-1:0] spk_cnt_q, spk_cnt_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              rate_valid_q, rate_valid_d;
    logic              evt;
    logic              run_active;

    assign evt        = spike & ~spike_q;
    assign run_active = (state_q == RUN) && en;

    always_comb begin
        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        spk_cnt_d    = spk_cnt_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                win_cnt_d = '0;
                spk_cnt_d = '0;
                if (en) state_d = RUN;
            end
            RUN: begin
                // Leaving RUN throws away the partial window and this cycle's edge.
                if (!run_active) begin
                    state_d   = IDLE;
                    win_cnt_d = '0;
                    spk_cnt_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                    if (win_cnt_q == WIN_LAST) begin
                        rate_d       = sat_add(spk_cnt_q, evt);
                        rate_valid_d = 1'b1;
                        spk_cnt_d    = '0;
                    end else begin
                        spk_cnt_d = sat_add(spk_cnt_q, evt);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            spike_q      <= 1'b0;
            win_cnt_q    <= '0;
            spk_cnt_q    <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            spike_q      <= spike;
            win_cnt_q    <= win_cnt_d;
            spk_cnt_q    <= spk_cnt_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;
    assign busy       = (state_q == RUN);

`ifdef SPIKE_ISI_EN
    spike_isi_meter u_isi (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run_active),
        .evt       (evt),
        .isi       (isi),
        .isi_valid (isi_valid)
    );
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder (WIN_W=4 and WIN_W=10 instances).
// Define SPIKE_ISI_EN to also check the interval outputs.
module tb_spike_rate_decoder;

    logic clk = 1'b0;
    logic rstN;
    logic en4, spike4, en10, spike10;
    logic [7:0] rate4, rate10;
    logic rateValid4, rateValid10, busy4, busy10;
`ifdef SPIKE_ISI_EN
    logic [7:0] isi4, isi10;
    logic isiValid4, isiValid10;
`endif

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;

    // Behavioural model state, index 0 = WIN_W 4, index 1 = WIN_W 10
    bit mPrev[2];
    bit mRun[2];
    int mRunIdx[2];
    int mEdges[2];
    int mRate[2];
    bit mRv[2];
    bit mHave[2];
    int mLast[2];
    int mIsi[2];
    bit mIv[2];

    int litQ4[$];
    int litQ10[$];
    int litIsi[$];

    always #5 clk = ~clk;

    spike_rate_decoder #(.WIN_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rstN),
        .en         (en4),
        .spike      (spike4),
        .rate       (rate4),
        .rate_valid (rateValid4),
`ifdef SPIKE_ISI_EN
        .isi        (isi4),
        .isi_valid  (isiValid4),
`endif
        .busy       (busy4)
    );

    spike_rate_decoder #(.WIN_W(10)) dut10 (
        .clk        (clk),
        .rst_n      (rstN),
        .en         (en10),
        .spike      (spike10),
        .rate       (rate10),
        .rate_valid (rateValid10),
`ifdef SPIKE_ISI_EN
        .isi        (isi10),
        .isi_valid  (isiValid10),
`endif
        .busy       (busy10)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic int minSat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            mPrev[k] = 0; mRun[k] = 0; mRunIdx[k] = 0; mEdges[k] = 0;
            mRate[k] = 0; mRv[k] = 0; mHave[k] = 0; mLast[k] = 0;
            mIsi[k] = 0; mIv[k] = 0;
        end
    endfunction

    // Rate = edges seen in each run-aligned window; ISI = gap between edge timestamps.
    function automatic void modelStep(input int k, input bit e, input bit s, input int t);
        int win;
        bit edgeSeen;
        win = (k == 0) ? 16 : 1024;
        edgeSeen = s && !mPrev[k];
        mPrev[k] = s;
        mRv[k] = 0;
        mIv[k] = 0;
        if (!mRun[k]) begin
            if (e) begin
                mRun[k] = 1; mRunIdx[k] = 0; mEdges[k] = 0; mHave[k] = 0;
            end
        end else if (!e) begin
            mRun[k] = 0;
        end else begin
            if (edgeSeen) begin
                mEdges[k]++;
                if (mHave[k]) begin
                    mIsi[k] = minSat(t - mLast[k]);
                    mIv[k] = 1;
                end
                mHave[k] = 1;
                mLast[k] = t;
            end
            if (mRunIdx[k] % win == win - 1) begin
                mRate[k] = minSat(mEdges[k]);
                mRv[k] = 1;
                mEdges[k] = 0;
            end
            mRunIdx[k]++;
        end
    endfunction

    task automatic checkOutput();
        cmp("rate4", rate4, mRate[0]);
        cmp("rate_valid4", rateValid4, mRv[0]);
        cmp("busy4", busy4, mRun[0]);
        cmp("rate10", rate10, mRate[1]);
        cmp("rate_valid10", rateValid10, mRv[1]);
        cmp("busy10", busy10, mRun[1]);
`ifdef SPIKE_ISI_EN
        cmp("isi4", isi4, mIsi[0]);
        cmp("isi_valid4", isiValid4, mIv[0]);
        cmp("isi10", isi10, mIsi[1]);
        cmp("isi_valid10", isiValid10, mIv[1]);
        if (isiValid4 === 1'b1 && litIsi.size() > 0) cmp("lit_isi4", isi4, litIsi.pop_front());
`endif
        if (rateValid4 === 1'b1 && litQ4.size() > 0) cmp("lit_rate4", rate4, litQ4.pop_front());
        if (rateValid10 === 1'b1 && litQ10.size() > 0) cmp("lit_rate10", rate10, litQ10.pop_front());
    endtask

    task automatic applyStimulus(input bit e4, input bit s4, input bit e10, input bit s10);
        en4 = e4; spike4 = s4; en10 = e10; spike10 = s10;
        @(posedge clk);
        if (rstN) begin
            modelStep(0, e4, s4, cycle);
            modelStep(1, e10, s10, cycle);
        end
        cycle++;
        #1;
        checkOutput();
    endtask

    task automatic checkZero(input string tag);
        cmp({tag, "_rate4"}, rate4, 0);
        cmp({tag, "_rv4"}, rateValid4, 0);
        cmp({tag, "_busy4"}, busy4, 0);
`ifdef SPIKE_ISI_EN
        cmp({tag, "_isi4"}, isi4, 0);
        cmp({tag, "_iv4"}, isiValid4, 0);
`endif
    endtask

    task automatic doReset(input string tag);
        rstN = 1'b0;
        #1;
        modelReset();
        checkZero(tag);
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        rstN = 1'b1;
    endtask

    // Drop en4 for two cycles, then spend one cycle entering RUN with spike low.
    task automatic restart4();
        applyStimulus(0, 0, en10, 0);
        applyStimulus(0, 0, en10, 0);
        applyStimulus(1, 0, en10, 0);
    endtask

    int lastPulse;
    int saved;

    initial begin
        rstN = 1'b0; en4 = 0; spike4 = 0; en10 = 0; spike10 = 0;
        modelReset();
        #12;
        doReset("reset");

        // Periodic spikes: 4 edges per 16-cycle window
        repeat (4) litQ4.push_back(4);
        lastPulse = -1;
        applyStimulus(1, 0, 0, 0);
        for (int i = 1; i <= 64; i++) begin
            applyStimulus(1, ((i - 1) % 4) == 0, 0, 0);
            if (rateValid4 === 1'b1) begin
                if (lastPulse >= 0) cmp("pulse_gap", cycle - lastPulse, 16);
                lastPulse = cycle;
            end
        end
        cmp("periodic_pulses_seen", litQ4.size(), 0);

        // Spike held high from run start
        litQ4.delete();
        litQ4.push_back(1); litQ4.push_back(0); litQ4.push_back(0);
        restart4();
        for (int j = 0; j < 48; j++) applyStimulus(1, 1, 0, 0);
        cmp("held_pulses_seen", litQ4.size(), 0);

        // Single edge in window cycle 15
        litQ4.delete();
        litQ4.push_back(1); litQ4.push_back(0);
        restart4();
        for (int j = 0; j < 32; j++) applyStimulus(1, j == 15, 0, 0);
        cmp("single_pulses_seen", litQ4.size(), 0);

        // Toggling spike on the wide window saturates; narrow DUT runs random
        litQ4.delete();
        litQ10.push_back(255); litQ10.push_back(255);
        applyStimulus(1, 0, 1, 0);
        for (int j = 0; j <= 2048; j++)
            applyStimulus($urandom_range(0, 63) != 0, $urandom_range(0, 3) == 0, 1, (j % 2) == 0);
        cmp("toggle_pulses_seen", litQ10.size(), 0);
        applyStimulus(0, 0, 0, 0);

        // Reset in the middle of a window, then count only new edges
        restart4();
        for (int j = 0; j <= 9; j++) applyStimulus(1, j == 1 || j == 3 || j == 5, 0, 0);
        doReset("midrst");
        litQ4.push_back(2);
        applyStimulus(1, 0, 0, 0);
        for (int j = 0; j < 16; j++) applyStimulus(1, j == 2 || j == 6, 0, 0);
        cmp("post_reset_pulses_seen", litQ4.size(), 0);

        // en dropped mid-window keeps the old rate and emits no pulse
        restart4();
        for (int j = 0; j < 23; j++) applyStimulus(1, $urandom_range(0, 1), 0, 0);
        saved = mRate[0];
        for (int j = 0; j < 20; j++) begin
            applyStimulus(0, $urandom_range(0, 1), 0, 0);
            cmp("drop_rv", rateValid4, 0);
            cmp("drop_rate", rate4, saved);
        end

`ifdef SPIKE_ISI_EN
        litIsi.push_back(7); litIsi.push_back(255);
        restart4();
        for (int j = 0; j <= 420; j++) applyStimulus(1, j == 10 || j == 17 || j == 400, 0, 0);
        cmp("isi_pulses_seen", litIsi.size(), 0);
`endif

        // Random traffic on both instances with varying spike density
        for (int blk = 0; blk < 12; blk++) begin
            int dens;
            dens = $urandom_range(1, 6);
            for (int j = 0; j < 250; j++)
                applyStimulus($urandom_range(0, 79) != 0, $urandom_range(0, dens) == 0,
                              $urandom_range(0, 199) != 0, $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
